mem_bus_arbiter: RTL and testbench

- Shares the single external memory port (QSPI/SRAM controller side) between three requesters:
  - instruction fetch (IMR stage),
  - data load/store (DMRW stage),
  - debug/loader port.
- Serializes one transaction at a time and returns read data plus a one-cycle done strobe to the owner.
- Drives per-requester busy levels, which feed the CPU sequencer's imr_run/dmrw_run inputs.

---
 rtl/mem_bus_arbiter_pkg.sv | 24 ++
 rtl/mem_arb_timeout.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: FSM encodings, grant ids and the
// RV32I NOP word returned on a timed-out read.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IF   = 2'd1;
  localparam logic [1:0] GNT_DM   = 2'd2;
  localparam logic [1:0] GNT_DBG  = 2'd3;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  // Fixed priority: debug beats data beats fetch.
  function automatic logic [1:0] pick_winner(input logic dbg, input logic dm, input logic fetch);
    if (dbg)        return GNT_DBG;
    else if (dm)    return GNT_DM;
    else if (fetch) return GNT_IF;
    else            return GNT_NONE;
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// ISSUE-phase watchdog: down-counter loaded on entry to ISSUE, flags expiry at terminal count.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timeout #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Loading TIMEOUT_CYC-1 makes the TIMEOUT_CYC-th ISSUE cycle the one at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(TIMEOUT_CYC - 1);
    end else if (active && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = active && (cnt_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Three-way arbiter (dbg > dm > if) serialising transactions onto one memory port.
// Optional ISSUE timeout with sticky mem_err is enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no owner; sample requests and latch the winner's command
// ST_ISSUE | mem_req held from the command register until mem_rdy (or timeout)
// ST_DONE  | one-cycle done strobe to the owner; requests ignored
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_done,
  output logic          if_busy,

  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_done,
  output logic          dm_busy,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic [31:0]   dbg_rdata,
  output logic          dbg_done,

  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_rdy,

  output logic [1:0]    grant_id,
  output logic          mem_err
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYC must be at least 1");
  end

  logic [1:0]    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          cmd_we_q, cmd_we_d;
  logic [3:0]    cmd_be_q, cmd_be_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [31:0]   cmd_wdata_q, cmd_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic [31:0]   dbg_rdata_q, dbg_rdata_d;

  logic          in_issue, in_done, any_req, issue_start, timeout_hit;
  logic [1:0]    winner;
  logic [31:0]   capture_word;

  assign in_issue     = (state_q == ST_ISSUE);
  assign in_done      = (state_q == ST_DONE);
  assign any_req      = if_req | dm_req | dbg_req;
  assign issue_start  = (state_q == ST_IDLE) && any_req;
  assign winner       = pick_winner(dbg_req, dm_req, if_req);
  // A real completion always wins over a simultaneous timeout.
  assign capture_word = mem_rdy ? mem_rdata : RV32I_NOP;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cmd_we_d    = cmd_we_q;
    cmd_be_d    = cmd_be_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ISSUE;
          gnt_d   = winner;
          case (winner)
            GNT_DBG: begin
              cmd_we_d    = dbg_we;
              cmd_be_d    = 4'hF;
              cmd_addr_d  = dbg_addr;
              cmd_wdata_d = dbg_wdata;
            end
            GNT_DM: begin
              cmd_we_d    = dm_we;
              cmd_be_d    = dm_be;
              cmd_addr_d  = dm_addr;
              cmd_wdata_d = dm_wdata;
            end
            default: begin
              cmd_we_d    = 1'b0;
              cmd_be_d    = 4'hF;
              cmd_addr_d  = if_addr;
              cmd_wdata_d = '0;
            end
          endcase
        end
      end

      ST_ISSUE: begin
        if (mem_rdy || timeout_hit) begin
          state_d = ST_DONE;
          if (!cmd_we_q) begin
            case (gnt_q)
              GNT_IF:  if_rdata_d  = capture_word;
              GNT_DM:  dm_rdata_d  = capture_word;
              GNT_DBG: dbg_rdata_d = capture_word;
              default: ;
            endcase
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_NONE;
      cmd_we_q    <= 1'b0;
      cmd_be_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cmd_we_q    <= cmd_we_d;
      cmd_be_q    <= cmd_be_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic mem_err_q, mem_err_d;

  mem_arb_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .start   (issue_start),
    .active  (in_issue),
    .expired (timeout_hit)
  );

  always_comb begin
    mem_err_d = mem_err_q | (in_issue & ~mem_rdy & timeout_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) mem_err_q <= 1'b0;
    else     mem_err_q <= mem_err_d;
  end

  assign mem_err = mem_err_q;
`else
  logic unused_start;
  assign unused_start = issue_start;
  assign timeout_hit  = 1'b0;
  assign mem_err      = 1'b0;
`endif

  // Command fields are only presented while a transaction is on the port.
  assign mem_req   = in_issue;
  assign mem_we    = in_issue & cmd_we_q;
  assign mem_be    = in_issue ? cmd_be_q    : '0;
  assign mem_addr  = in_issue ? cmd_addr_q  : '0;
  assign mem_wdata = in_issue ? cmd_wdata_q : '0;

  assign grant_id  = gnt_q;
  assign if_done   = in_done && (gnt_q == GNT_IF);
  assign dm_done   = in_done && (gnt_q == GNT_DM);
  assign dbg_done  = in_done && (gnt_q == GNT_DBG);
  assign if_busy   = if_req & ~if_done;
  assign dm_busy   = dm_req & ~dm_done;

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a priority/scoreboard model.
module tb_mem_bus_arbiter;

  localparam int AW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_done, if_busy;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          dm_req, dm_we, dm_done, dm_busy;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata, dm_rdata;
  logic          dbg_req, dbg_we, dbg_done;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata, dbg_rdata;
  logic          mem_req, mem_we, mem_rdy;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [1:0]    grant_id;
  logic          mem_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_busy(if_busy),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_busy(dm_busy),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .grant_id(grant_id), .mem_err(mem_err)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rdata [1:3];

  typedef struct {
    logic [2:0]  req;      // {dbg, dm, if}
    logic        we;
    logic [3:0]  be;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          wcyc;
    logic [31:0] rd;
    logic [1:0]  e_gnt;
    logic        e_we;
    logic [3:0]  e_be;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drop_req(input logic [1:0] g);
    case (g)
      2'd1: if_req = 1'b0;
      2'd2: dm_req = 1'b0;
      2'd3: dbg_req = 1'b0;
      default: ;
    endcase
  endtask

  task automatic check_rdata();
    chk("if_rdata", if_rdata, exp_rdata[1]);
    chk("dm_rdata", dm_rdata, exp_rdata[2]);
    chk("dbg_rdata", dbg_rdata, exp_rdata[3]);
  endtask

  // One transaction from current position until the IDLE cycle after DONE.
  task automatic run_txn(input logic [1:0] eg, input logic ewe, input logic [3:0] ebe,
                         input logic [15:0] eaddr, input logic [31:0] ewdata,
                         input int wcyc, input logic [31:0] rd, input bit perturb);
    int n = 0;
    while (!mem_req && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("mem_req_seen", mem_req, 1'b1);
    if (!mem_req) return;
    chk("grant_id", grant_id, eg);
    chk("issue_cmd", {mem_we, mem_be, mem_addr}, {ewe, ebe, eaddr});
    if (eg != 2'd1) chk("issue_wdata", mem_wdata, ewdata);
    chk("busy_wait", {dm_busy, if_busy}, {dm_req, if_req});
    for (int i = 0; i < wcyc; i++) begin
      if (perturb) begin
        case (eg)
          2'd1: if_addr = ~if_addr;
          2'd2: begin dm_addr = ~dm_addr; dm_wdata = ~dm_wdata; dm_be = ~dm_be; dm_we = ~dm_we; end
          2'd3: begin dbg_addr = ~dbg_addr; dbg_wdata = ~dbg_wdata; dbg_we = ~dbg_we; end
          default: ;
        endcase
      end
      @(negedge clk);
      chk("issue_hold", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, ewe, ebe, eaddr});
      if (eg != 2'd1) chk("hold_wdata", mem_wdata, ewdata);
      chk("no_early_done", {dbg_done, dm_done, if_done}, 3'b000);
    end
    mem_rdata = rd;
    mem_rdy = 1'b1;
    @(negedge clk);
    mem_rdy = 1'b0;
    mem_rdata = $urandom;
    chk("done_onehot", {dbg_done, dm_done, if_done}, 3'b001 << (eg - 2'd1));
    chk("done_mem_req", mem_req, 1'b0);
    if (!ewe) exp_rdata[eg] = rd;
    check_rdata();
    if (eg == 2'd1) chk("if_busy_done", if_busy, 1'b0);
    if (eg == 2'd2) chk("dm_busy_done", dm_busy, 1'b0);
    drop_req(eg);
    @(negedge clk);
    chk("idle_after", {dbg_done, dm_done, if_done, mem_req, grant_id}, 6'b0);
    chk("busy_idle", {dm_busy, if_busy}, {dm_req, if_req});
  endtask

  task automatic apply_fields(input logic [2:0] rq, input logic we, input logic [3:0] be,
                              input logic [15:0] addr, input logic [31:0] wd);
    if_addr = addr;
    dm_we = we; dm_be = be; dm_addr = addr; dm_wdata = wd;
    dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    {dbg_req, dm_req, if_req} = rq;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  w;
    logic        ewe;
    logic [3:0]  ebe;
    logic [15:0] eaddr;
    logic [31:0] ewd;

    vecs[0] = '{3'b001, 1'b1, 4'b0011, 16'h0010, 32'h1111_2222, 3, 32'h0050_0093, 2'd1, 1'b0, 4'hF};
    vecs[1] = '{3'b010, 1'b1, 4'b0011, 16'h0200, 32'hDEAD_BEEF, 2, 32'h1234_5678, 2'd2, 1'b1, 4'b0011};
    vecs[2] = '{3'b010, 1'b0, 4'b1100, 16'h0204, 32'h0000_0000, 0, 32'hCAFE_F00D, 2'd2, 1'b0, 4'b1100};
    vecs[3] = '{3'b100, 1'b1, 4'b0001, 16'h0300, 32'h0BAD_C0DE, 1, 32'h7777_7777, 2'd3, 1'b1, 4'hF};
    vecs[4] = '{3'b100, 1'b0, 4'b0000, 16'h0304, 32'h0000_0000, 4, 32'hA5A5_5A5A, 2'd3, 1'b0, 4'hF};
    vecs[5] = '{3'b001, 1'b0, 4'b0000, 16'h0014, 32'h0000_0000, 1, 32'h00A0_0113, 2'd1, 1'b0, 4'hF};

    rst = 1'b1;
    apply_fields(3'b000, 1'b0, 4'h0, 16'h0, 32'h0);
    mem_rdy = 1'b0; mem_rdata = 32'h0;
    for (int i = 1; i <= 3; i++) exp_rdata[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {grant_id, mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 0);
    chk("rst_done", {dbg_done, dm_done, if_done, mem_err}, 4'b0);
    check_rdata();
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      apply_fields(vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      run_txn(vecs[i].e_gnt, vecs[i].e_we, vecs[i].e_be, vecs[i].addr, vecs[i].wdata,
              vecs[i].wcyc, vecs[i].rd, 1'b0);
    end

    // Simultaneous requests: service order dbg, dm, if.
    if_addr = 16'h0100;
    dm_we = 1'b0; dm_be = 4'b0110; dm_addr = 16'h0110; dm_wdata = 32'h0;
    dbg_we = 1'b0; dbg_addr = 16'h0120; dbg_wdata = 32'h0;
    {dbg_req, dm_req, if_req} = 3'b111;
    run_txn(2'd3, 1'b0, 4'hF, 16'h0120, 32'h0, 1, 32'h3333_0003, 1'b0);
    run_txn(2'd2, 1'b0, 4'b0110, 16'h0110, 32'h0, 0, 32'h2222_0002, 1'b0);
    run_txn(2'd1, 1'b0, 4'hF, 16'h0100, 32'h0, 2, 32'h1111_0001, 1'b0);

    // Zero-wait memory: done two cycles after the request is sampled.
    if_addr = 16'h0020; if_req = 1'b1;
    @(negedge clk);
    chk("zw_latency", {mem_req, grant_id}, {1'b1, 2'd1});
    mem_rdata = 32'h0010_0073; mem_rdy = 1'b1;
    @(negedge clk);
    mem_rdy = 1'b0;
    chk("zw_done", if_done, 1'b1);
    exp_rdata[1] = 32'h0010_0073;
    chk("zw_rdata", if_rdata, exp_rdata[1]);
    if_req = 1'b0;
    @(negedge clk);
    chk("zw_done_once", if_done, 1'b0);

    // mem_rdy while idle is ignored.
    mem_rdata = 32'hFFFF_FFFF; mem_rdy = 1'b1;
    repeat (2) @(negedge clk);
    mem_rdy = 1'b0;
    chk("idle_rdy_ignored", {dbg_done, dm_done, if_done, mem_req}, 4'b0);
    check_rdata();

    // No preemption: dbg arriving during a dm ISSUE waits.
    dm_we = 1'b0; dm_be = 4'hF; dm_addr = 16'h0400; dm_req = 1'b1;
    @(negedge clk);
    chk("np_grant", grant_id, 2'd2);
    dbg_we = 1'b0; dbg_addr = 16'h0500; dbg_req = 1'b1;
    run_txn(2'd2, 1'b0, 4'hF, 16'h0400, 32'h0, 2, 32'h4444_0004, 1'b0);
    run_txn(2'd3, 1'b0, 4'hF, 16'h0500, 32'h0, 0, 32'h5555_0005, 1'b0);

    // Reset during ISSUE aborts without a done.
    if_addr = 16'h0040; if_req = 1'b1;
    @(negedge clk);
    chk("rsti_issue", mem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rsti_abort", {mem_req, grant_id, dbg_done, dm_done, if_done}, 6'b0);
    for (int i = 1; i <= 3; i++) exp_rdata[i] = 32'h0;
    check_rdata();
    rst = 1'b0;
    run_txn(2'd1, 1'b0, 4'hF, 16'h0040, 32'h0, 1, 32'h0000_6F6F, 1'b0);

    // Randomized traffic against the priority/scoreboard model.
    for (int it = 0; it < 30; it++) begin
      if_addr = 16'($urandom);
      dm_we = 1'($urandom); dm_be = 4'($urandom); dm_addr = 16'($urandom); dm_wdata = $urandom;
      dbg_we = 1'($urandom); dbg_addr = 16'($urandom); dbg_wdata = $urandom;
      {dbg_req, dm_req, if_req} = 3'($urandom_range(1, 7));
      while (dbg_req || dm_req || if_req) begin
        if (dbg_req) begin
          w = 2'd3; ewe = dbg_we; ebe = 4'hF; eaddr = dbg_addr; ewd = dbg_wdata;
        end else if (dm_req) begin
          w = 2'd2; ewe = dm_we; ebe = dm_be; eaddr = dm_addr; ewd = dm_wdata;
        end else begin
          w = 2'd1; ewe = 1'b0; ebe = 4'hF; eaddr = if_addr; ewd = 32'h0;
        end
        run_txn(w, ewe, ebe, eaddr, ewd, int'($urandom_range(0, 3)), $urandom, 1'($urandom));
      end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int n = 0;
      int cyc = 0;
      if_addr = 16'h0080; if_req = 1'b1;
      while (!mem_req && n < 6) begin
        @(negedge clk);
        n++;
      end
      while (mem_req && cyc < 40) begin
        cyc++;
        @(negedge clk);
      end
      chk("to_issue_cycles", cyc, TO);
      chk("to_done", if_done, 1'b1);
      exp_rdata[1] = 32'h0000_0013;
      chk("to_rdata_nop", if_rdata, exp_rdata[1]);
      if_req = 1'b0;
      @(negedge clk);
      chk("to_err", mem_err, 1'b1);
      dm_we = 1'b0; dm_be = 4'hF; dm_addr = 16'h0600; dm_req = 1'b1;
      run_txn(2'd2, 1'b0, 4'hF, 16'h0600, 32'h0, 1, 32'h6666_0006, 1'b0);
      chk("to_err_sticky", mem_err, 1'b1);
    end
`else
    chk("mem_err_tied", mem_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
